// File: rtl/shreg194_pkg.sv
// Shared types and constants for the 74x194 command sequencer: op codes,
// register mode selects, FSM states and the latched command record.
package shreg194_pkg;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_SHR  = 2'b01,
    OP_SHL  = 2'b10,
    OP_ROTR = 2'b11
  } op_e;

  // S1S0 encodings understood by the 74x194
  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_SHIFT = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  typedef struct packed {
    op_e        op;
    logic [3:0] data;
    logic       fill;
  } cmd_t;

  // Rotate-right reuses the shift-right mode; only the serial source differs.
  function automatic logic [1:0] shift_mode(input op_e op);
    return (op == OP_SHL) ? MODE_SHL : MODE_SHR;
  endfunction

endpackage

// File: rtl/shreg194_downcnt.sv
// Loadable down-counter that tracks the remaining shifts of a command and
// flags the final one.
module shreg194_downcnt #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             last
);

  logic [CNT_W-1:0] count;

  // NOTE: state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign last = (count == CNT_W'(1));

endmodule

// File: rtl/shreg194_seq.sv
// Command sequencer for an external 74x194 universal shift register sharing
// clk: turns LOAD/SHR/SHL/ROTR commands into timed S1/S0 and serial/parallel drive.
module shreg194_seq
  import shreg194_pkg::*;
#(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [3:0]       cmd_data,
  input  logic [CNT_W-1:0] cmd_cnt,
  input  logic             cmd_fill,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [3:0]       rsp_q,
  output logic             busy,
  output logic             sr_clr_l,
  output logic             sr_s1,
  output logic             sr_s0,
  output logic             sr_lin,
  output logic             sr_rin,
  output logic [3:0]       sr_par,
  input  logic [3:0]       sr_q
);

  state_e     state, state_d;
  cmd_t       cmd_q;
  logic       accept;
  logic       cnt_last;
  logic [1:0] mode;

  assign cmd_ready = (state == ST_IDLE) && !clr;
  assign accept    = cmd_valid && cmd_ready;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= ST_IDLE;
      cmd_q <= '0;
    end else begin
      state <= state_d;
      if (accept) begin
        cmd_q.op   <= op_e'(cmd_op);
        cmd_q.data <= cmd_data;
        cmd_q.fill <= cmd_fill;
      end
    end
  end

  // The counter is loaded on every accept; LOAD simply never looks at it.
  shreg194_downcnt #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .clr      (clr),
    .load     (accept),
    .load_val (cmd_cnt),
    .dec      (state == ST_SHIFT),
    .last     (cnt_last)
  );

  // NOTE: every always_comb target gets a default first so no latch is inferred.
  always_comb begin
    state_d = state;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          if (op_e'(cmd_op) == OP_LOAD) begin
            state_d = ST_LOAD;
          end else if (cmd_cnt == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_SHIFT;
          end
        end
      end
      ST_LOAD:  state_d = ST_DONE;
      ST_SHIFT: if (cnt_last) state_d = ST_DONE;
      ST_DONE:  if (rsp_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Register drive decodes from latched state only; ROTR feeds QD back to RIN.
  always_comb begin
    mode   = MODE_HOLD;
    sr_par = '0;
    sr_lin = 1'b0;
    sr_rin = 1'b0;
    unique case (state)
      ST_LOAD: begin
        mode   = MODE_LOAD;
        sr_par = cmd_q.data;
      end
      ST_SHIFT: begin
        mode = shift_mode(cmd_q.op);
        unique case (cmd_q.op)
          OP_SHL:  sr_lin = cmd_q.fill;
          OP_ROTR: sr_rin = sr_q[0];
          default: sr_rin = cmd_q.fill;
        endcase
      end
      default: ;
    endcase
  end

  assign sr_s1     = mode[1];
  assign sr_s0     = mode[0];
  assign sr_clr_l  = !clr;
  assign busy      = (state != ST_IDLE);
  assign rsp_valid = (state == ST_DONE);
  assign rsp_q     = sr_q;

endmodule
